// File: rtl/alu_mc.sv
// alu_mc: registered EX-stage ALU with valid/ready handshakes and a
// shift-add multiplier. Legacy opcodes 0000-0011 keep ADD/SUB/AND/OR.
module alu_mc #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned MUL_EN = 1,
    parameter int unsigned SHW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);

    // Counter must hold the value WIDTH itself, hence one extra bit.
    localparam int unsigned CW = SHW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             is_mul;
    logic             accept;
    logic [WIDTH-1:0] acc_step;

    assign add_full = {1'b0, a} + {1'b0, b};
    assign diff     = a - b;
    assign shamt    = b[SHW-1:0];
    assign is_mul   = (MUL_EN != 0) && (alu_ctrl == 4'b1010);
    assign accept   = in_valid && in_ready;
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Single-cycle datapath: result and flags for every non-MUL opcode.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        unique case (alu_ctrl)
            4'b0000: begin
                alu_res   = add_full[WIDTH-1:0];
                alu_carry = add_full[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0001: begin
                alu_res   = diff;
                alu_carry = (a >= b);
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0010: alu_res = a & b;
            4'b0011: alu_res = a | b;
            4'b0100: alu_res = a ^ b;
            4'b0101: alu_res = WIDTH'($signed(a) < $signed(b));
            4'b0110: alu_res = WIDTH'(a < b);
            4'b0111: alu_res = a << shamt;
            4'b1000: alu_res = a >> shamt;
            4'b1001: alu_res = WIDTH'($signed(a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, iterate in MUL, hold until drained in DONE.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = CW'(WIDTH);
                        state_d  = S_MUL;
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        neg_d       = alu_res[WIDTH-1];
                        carry_d     = alu_carry;
                        ovf_d       = alu_ovf;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d    = acc_step;
                    zero_d      = (acc_step == '0);
                    neg_d       = acc_step[WIDTH-1];
                    carry_d     = 1'b0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign negative  = neg_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed vector table, hand sequences for handshake and
// reset corners, and random ops against an arithmetic reference model.
// Two instances: WIDTH=32 and WIDTH=8.
module tb_alu_mc;

    logic        clk;
    logic        rst;
    logic [31:0] a_s, b_s;
    logic [3:0]  op_s;
    logic        out_ready_s;

    logic        iv32, ir32, ov32, z32, n32, c32, v32, busy32;
    logic [31:0] res32;
    logic        iv8, ir8, ov8, z8, n8, c8, v8, busy8;
    logic [7:0]  res8;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          w;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    alu_mc #(.WIDTH(32), .MUL_EN(1)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .a(a_s), .b(b_s), .alu_ctrl(op_s), .out_valid(ov32), .out_ready(out_ready_s),
        .result(res32), .zero(z32), .negative(n32), .carry(c32), .overflow(v32), .busy(busy32)
    );

    alu_mc #(.WIDTH(8), .MUL_EN(1)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a_s[7:0]), .b(b_s[7:0]), .alu_ctrl(op_s), .out_valid(ov8), .out_ready(out_ready_s),
        .result(res8), .zero(z8), .negative(n8), .carry(c8), .overflow(v8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] cur_res(input int w);
        return (w == 8) ? {24'h0, res8} : res32;
    endfunction
    function automatic logic [3:0] cur_fl(input int w);
        return (w == 8) ? {z8, n8, c8, v8} : {z32, n32, c32, v32};
    endfunction
    function automatic logic cur_ov(input int w);
        return (w == 8) ? ov8 : ov32;
    endfunction
    function automatic logic cur_ir(input int w);
        return (w == 8) ? ir8 : ir32;
    endfunction
    function automatic logic cur_busy(input int w);
        return (w == 8) ? busy8 : busy32;
    endfunction

    task automatic set_iv(input int w, input logic v);
        if (w == 8) iv8 = v; else iv32 = v;
    endtask

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Two's-complement value of a w-bit pattern.
    function automatic longint sx(input int w, input longint unsigned v);
        if (((v >> (w - 1)) & 64'd1) != 0)
            return longint'(v) - (longint'(1) << w);
        return longint'(v);
    endfunction

    // Reference model from the opcode definitions, in plain integer arithmetic.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, output logic [31:0] r, output logic [3:0] f);
        longint unsigned m, ua, ub, res;
        longint sa, sb, smax, smin, s;
        int amt;
        bit c, v;
        m    = (64'd1 << w) - 64'd1;
        ua   = {32'h0, a} & m;
        ub   = {32'h0, b} & m;
        sa   = sx(w, ua);
        sb   = sx(w, ub);
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        amt  = int'(ub % longint'(w));
        c    = 1'b0;
        v    = 1'b0;
        res  = 0;
        case (op)
            4'd0: begin
                res = (ua + ub) & m;
                c   = ((ua + ub) >> w) != 0;
                s   = sa + sb;
                v   = (s > smax) || (s < smin);
            end
            4'd1: begin
                res = (ua - ub) & m;
                c   = ua >= ub;
                s   = sa - sb;
                v   = (s > smax) || (s < smin);
            end
            4'd2:  res = ua & ub;
            4'd3:  res = ua | ub;
            4'd4:  res = ua ^ ub;
            4'd5:  res = (sa < sb) ? 1 : 0;
            4'd6:  res = (ua < ub) ? 1 : 0;
            4'd7:  res = (ua << amt) & m;
            4'd8:  res = ua >> amt;
            4'd9:  res = longint'(unsigned'(sa >>> amt)) & m;
            4'd10: res = (ua * ub) & m;
            default: res = 0;
        endcase
        r = res[31:0];
        f = {res == 0, ((res >> (w - 1)) & 1) != 0, c, v};
    endtask

    // Issue one op, optionally keep in_valid high while busy, optionally stall
    // out_ready for 'hold' cycles, then drain. lat = edges from accept to out_valid.
    task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input int hold, input bit poke,
                         output logic [31:0] r, output logic [3:0] f, output int lat);
        int guard, busy_bad, hold_bad;
        guard = 0;
        while (!cur_ir(w) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("in_ready_before_issue", cur_ir(w), 1);
        a_s = a; b_s = b; op_s = op;
        set_iv(w, 1'b1);
        @(posedge clk); #1;
        a_s = $urandom; b_s = $urandom; op_s = 4'($urandom);
        if (!poke) set_iv(w, 1'b0);
        lat = 1;
        busy_bad = 0;
        while (!cur_ov(w) && lat < 200) begin
            if (cur_ir(w)) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        set_iv(w, 1'b0);
        if (poke) chk("in_ready_low_while_busy", busy_bad, 0);
        r = cur_res(w);
        f = cur_fl(w);
        hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (cur_res(w) !== r || cur_fl(w) !== f || cur_ov(w) !== 1'b1 || cur_ir(w) !== 1'b0)
                hold_bad++;
        end
        if (hold > 0) chk("done_hold_stable", hold_bad, 0);
        out_ready_s = 1'b1;
        @(posedge clk); #1;
        out_ready_s = 1'b0;
        chk("out_valid_drop", cur_ov(w), 0);
        chk("in_ready_rise", cur_ir(w), 1);
    endtask

    task automatic add_vec(input int w, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [31:0] res, input logic [3:0] fl,
                           input int lat);
        vec_t e;
        e.w = w; e.a = a; e.b = b; e.op = op; e.res = res; e.fl = fl; e.lat = lat;
        tbl.push_back(e);
    endtask

    initial begin
        logic [31:0] r, er, ra, rb;
        logic [3:0]  f, ef, rop;
        int          lat;
        int          w;

        rst = 1'b1; iv32 = 1'b0; iv8 = 1'b0; out_ready_s = 1'b0;
        a_s = '0; b_s = '0; op_s = '0;

        // flags column is {zero, negative, carry, overflow}
        add_vec(32, 32'h7FFFFFFF, 32'h1,        4'd0,  32'h80000000, 4'b0101, 1);
        add_vec(32, 32'hFFFFFFFF, 32'h1,        4'd0,  32'h00000000, 4'b1010, 1);
        add_vec(32, 32'h5,        32'h7,        4'd1,  32'hFFFFFFFE, 4'b0100, 1);
        add_vec(32, 32'hFFFFFFFF, 32'h1,        4'd5,  32'h1,        4'b0000, 1);
        add_vec(32, 32'hFFFFFFFF, 32'h1,        4'd6,  32'h0,        4'b1000, 1);
        add_vec(32, 32'h80000000, 32'h24,       4'd9,  32'hF8000000, 4'b0100, 1);
        add_vec(32, 32'h80000000, 32'h24,       4'd8,  32'h08000000, 4'b0000, 1);
        add_vec(32, 32'h1,        32'd31,       4'd7,  32'h80000000, 4'b0100, 1);
        add_vec(32, 32'h80000001, 32'h20,       4'd9,  32'h80000001, 4'b0100, 1);
        add_vec(32, 32'hA5A5A5A5, 32'hFFFF0000, 4'd4,  32'h5A5AA5A5, 4'b0000, 1);
        add_vec(32, 32'h5,        32'h3,        4'd15, 32'h0,        4'b1000, 1);
        add_vec(32, 32'h00010001, 32'h00010001, 4'd10, 32'h00020001, 4'b0000, 33);
        add_vec(8,  32'h7F,       32'h1,        4'd0,  32'h80,       4'b0101, 1);
        add_vec(8,  32'hFF,       32'h1,        4'd0,  32'h00,       4'b1010, 1);
        add_vec(8,  32'h5,        32'h7,        4'd1,  32'hFE,       4'b0100, 1);
        add_vec(8,  32'h80,       32'h1,        4'd1,  32'h7F,       4'b0011, 1);
        add_vec(8,  32'hFF,       32'h1,        4'd5,  32'h1,        4'b0000, 1);
        add_vec(8,  32'hFF,       32'h1,        4'd6,  32'h0,        4'b1000, 1);
        add_vec(8,  32'h80,       32'h24,       4'd9,  32'hF8,       4'b0100, 1);
        add_vec(8,  32'h80,       32'h24,       4'd8,  32'h08,       4'b0000, 1);
        add_vec(8,  32'h1,        32'h7,        4'd7,  32'h80,       4'b0100, 1);
        add_vec(8,  32'h11,       32'h11,       4'd10, 32'h21,       4'b0000, 9);
        add_vec(8,  32'hFF,       32'hFF,       4'd10, 32'h01,       4'b0000, 9);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("in_ready_during_rst", {ir32, ir8}, 2'b00);
        rst = 1'b0;
        #1;
        chk("reset_ready", {ir32, ir8}, 2'b11);
        chk("reset_valid_busy", {ov32, ov8, busy32, busy8}, 4'b0000);
        chk("reset_res32", res32, 0);
        chk("reset_flags", {z32, n32, c32, v32, z8, n8, c8, v8}, 8'h00);

        // out_ready while idle must not produce anything
        out_ready_s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("out_ready_idle_ignored", {ov32, ov8, ir32, ir8}, 4'b0011);
        out_ready_s = 1'b0;

        // Directed table; MUL entries also keep in_valid raised while busy
        foreach (tbl[i]) begin
            do_op(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].op, 0, tbl[i].op == 4'd10, r, f, lat);
            chk($sformatf("vec%0d_res", i), r, tbl[i].res);
            chk($sformatf("vec%0d_flags", i), f, tbl[i].fl);
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
        end

        // Stall in DONE for 5 cycles, then confirm a fresh op is accepted
        do_op(32, 32'h7FFFFFFF, 32'h1, 4'd0, 5, 0, r, f, lat);
        chk("hold_res", r, 32'h80000000);
        chk("hold_flags", f, 4'b0101);
        do_op(32, 32'hF0F0F0F0, 32'h0FF00FF0, 4'd3, 0, 0, r, f, lat);
        chk("after_hold_res", r, 32'hFFF0FFF0);

        // Reset at C+10 of a MUL
        a_s = 32'h1234; b_s = 32'h5678; op_s = 4'd10;
        iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mul_busy_before_rst", busy32, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_mul_res", res32, 0);
        chk("rst_mid_mul_ctl", {ov32, busy32, ir32, z32, n32, c32, v32}, 7'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_release_ready", {ir32, ov32, busy32}, 3'b100);
        do_op(32, 32'd6, 32'd7, 4'd10, 0, 0, r, f, lat);
        chk("post_rst_mul_res", r, 32'd42);
        chk("post_rst_mul_lat", lat, 33);

        // Random ops on both widths against the model
        for (int k = 0; k < 60; k++) begin
            w   = (k % 2 == 0) ? 32 : 8;
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 70)) : $urandom;
            if (k % 7 == 0) rb = ra;
            model(w, ra, rb, rop, er, ef);
            do_op(w, ra, rb, rop, k % 5 == 0 ? 2 : 0, k % 3 == 0, r, f, lat);
            chk($sformatf("rnd%0d_w%0d_op%0d_res", k, w, rop), r, er);
            chk($sformatf("rnd%0d_w%0d_op%0d_flags", k, w, rop), f, ef);
            chk($sformatf("rnd%0d_w%0d_op%0d_lat", k, w, rop), lat, rop == 4'd10 ? w + 1 : 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, registered successor to the CPU's combinational 32-bit ALU.
- Adds XOR, signed/unsigned compare, shifts and an iterative shift-add multiply.
- Exposes zero/negative/carry/overflow flags and uses valid/ready handshakes on both sides.
- Sits in the EX stage; the pipeline stalls on in_ready/out_valid. Opcodes 0000-0011 keep the legacy ADD/SUB/AND/OR meaning.

Parameters:
- WIDTH, 32, operand/result width; legal values are >= 4 and a power of 2.
- MUL_EN, 1, 1 = MUL implemented; 0 = opcode 1010 treated as undefined.
- SHW, $clog2(WIDTH), shift-amount bits taken from b (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B / shift amount
- alu_ctrl  in  4  opcode
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- negative  out  1  result[WIDTH-1]
- carry  out  1  ADD carry-out / SUB no-borrow
- overflow  out  1  signed overflow (ADD/SUB)
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, MUL, DONE. Reset (any time, including mid-MUL) forces IDLE, result=0, all flags=0, out_valid=0, multiply counter=0. Any in-flight operation is discarded.
- in_ready = (state==IDLE) and not rst. Accept happens in cycle C when in_valid && in_ready; a, b, alu_ctrl are sampled then. Later input changes are ignored until the next accept.
- Opcodes:
  - 0000 ADD
  - 0001 SUB (a-b)
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLT (signed a<b -> 1, else 0)
  - 0110 SLTU (unsigned)
  - 0111 SLL (a << b[SHW-1:0])
  - 1000 SRL (logical)
  - 1001 SRA (arithmetic, sign-filled)
  - 1010 MUL (low WIDTH bits of a*b; signedness irrelevant)
  - Others: result=0.
- Single-cycle ops: result and flags computed at accept. State -> DONE, out_valid=1 in cycle C+1.
- MUL: state -> MUL for exactly WIDTH cycles (C+1..C+WIDTH).
  - Each cycle: if multiplier LSB is set, add the multiplicand to the accumulator; shift the multiplicand left by 1 and the multiplier right by 1; decrement the counter (counter loads WIDTH at accept).
  - When the counter reaches 0, go to DONE; out_valid=1 in cycle C+WIDTH+1.
  - Wrap-around: overflow beyond WIDTH bits is discarded.
- DONE: result and flags are held stable while out_valid=1 && !out_ready. When out_ready=1, go to IDLE next edge; out_valid drops and in_ready rises the same cycle. Back-to-back throughput is therefore 1 op per 2 cycles minimum.
- Flags are registered alongside result:
  - zero = (result==0); this includes undefined opcodes, giving zero=1.
  - negative = result MSB.
  - carry: ADD = carry-out of the WIDTH-bit add; SUB = 1 iff a >= b unsigned; all other ops 0.
  - overflow: ADD = a and b same sign and result sign differs; SUB = a and b signs differ and result sign differs from a; all other ops 0.
- Boundary cases:
  - Shift amount uses only the low SHW bits of b; upper bits are ignored.
  - SRA by 0 returns a.
  - in_valid while busy: no accept, no side effects.
  - out_ready asserted outside DONE: ignored.
  - MUL with MUL_EN=0: handled as an undefined opcode (1-cycle, result 0, zero=1).

Test Plan:
1. Reset, then ADD a=0x7FFFFFFF, b=1 -> out_valid at C+1; result=0x80000000, overflow=1, negative=1, carry=0, zero=0. ADD a=0xFFFFFFFF, b=1 -> result=0, carry=1, zero=1, overflow=0.
2. SUB a=5, b=7 -> result=0xFFFFFFFE, carry=0, negative=1. SLT a=0xFFFFFFFF, b=1 -> 1; SLTU same operands -> 0.
3. SRA a=0x80000000, b=0x24 (amount=4) -> 0xF8000000. SRL same -> 0x08000000. SLL a=1, b=31 -> 0x80000000.
4. MUL a=0x10001, b=0x10001 -> out_valid exactly at C+33 (WIDTH=32), result=0x00020001. in_valid pulsed during MUL is not accepted and in_ready stays 0.
5. Hold out_ready=0 for 5 cycles in DONE -> result and flags stable, in_ready=0. Raise out_ready -> IDLE next cycle, then a new op is accepted.
6. Assert rst at C+10 of a MUL -> all outputs 0 and in_ready=1 immediately after rst deasserts. Repeat tests 1-4 with WIDTH=8 (MUL latency 9).
